// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier with a start/busy/done handshake.
// Retires one Booth digit per clock. Signed or unsigned operands are chosen per operation,
// and the double-width product is held until the next result replaces it.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Each digit covers two multiplier bits. The extra digit absorbs the two
    // extension bits, so unsigned operands need no special handling.
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);
    // Accumulator precision: the extended multiplicand (WIDTH+2) plus one bit for the 2A case.
    localparam int AW   = WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH+1:0]   mcand;    // multiplicand extended by two bits
    logic [AW-1:0]      acc_hi;   // upper half of the running product
    logic [AW-1:0]      mplr;     // {extended multiplier, implicit 0}; the window sits in bits [2:0]

    logic [AW-1:0]      a_x;
    logic [AW-1:0]      pp;
    logic [AW-1:0]      sum;
    logic [2*AW-1:0]    shifted;

    assign a_x = {mcand[WIDTH+1], mcand};

    // Booth digit selection from the current 3-bit window, then accumulate and shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first; otherwise a missed case infers a latch.
        pp = '0;
        unique case (mplr[2:0])
            3'b001, 3'b010: pp = a_x;
            3'b011:         pp = a_x << 1;
            3'b100:         pp = -(a_x << 1);
            3'b101, 3'b110: pp = -a_x;
            default:        pp = '0;
        endcase
        sum     = acc_hi + pp;
        // Arithmetic right shift by two of {sum, mplr}: replicate the sign bit into the top.
        shifted = {{2{sum[AW-1]}}, sum, mplr[AW-1:2]};
    end

    // Control FSM and datapath registers, with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            count   <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            mplr    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= CW'(ITER);
                        acc_hi <= '0;
                        if (is_signed) begin
                            mcand <= {{2{a[WIDTH-1]}}, a};
                            mplr  <= {{2{b[WIDTH-1]}}, b, 1'b0};
                        end else begin
                            mcand <= {2'b00, a};
                            mplr  <= {2'b00, b, 1'b0};
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= shifted[2*AW-1:AW];
                    mplr   <= shifted[AW-1:0];
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // Bit 0 still holds the leftover multiplier sign bit, so the
                        // product starts at bit 1.
                        product <= shifted[2*WIDTH:1];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq. It runs a WIDTH=32 instance for the directed
// handshake cases and a WIDTH=8 instance for the random sweep.
module tb_booth_mul_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=32 instance
    logic        start32 = 1'b0;
    logic        s32     = 1'b0;
    logic [31:0] a32     = '0;
    logic [31:0] b32     = '0;
    logic        busy32;
    logic        done32;
    logic [63:0] prod32;

    // WIDTH=8 instance
    logic        start8 = 1'b0;
    logic        s8     = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    booth_mul_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(s32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference product: extends both operands as the mode requires and keeps 2*WIDTH bits.
    function automatic logic [63:0] ref_mul(input bit w8, input logic [31:0] a, input logic [31:0] b,
                                            input bit s);
        longint xa;
        longint xb;
        longint p;
        if (w8) begin
            if (s) begin
                xa = longint'($signed(a[7:0]));
                xb = longint'($signed(b[7:0]));
            end else begin
                xa = longint'(a[7:0]);
                xb = longint'(b[7:0]);
            end
            p = xa * xb;
            return {48'b0, p[15:0]};
        end
        if (s) begin
            xa = longint'($signed(a));
            xb = longint'($signed(b));
        end else begin
            xa = longint'(a);
            xb = longint'(b);
        end
        p = xa * xb;
        return p;
    endfunction

    // Drive a request (called at a negedge) and push its expected product to the scoreboard.
    task automatic launch(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit s,
                          input logic [63:0] exp);
        if (w8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
        end else begin
            start32 = 1'b1; a32 = a; b32 = b; s32 = s;
        end
        sb_q.push_back(exp);
    endtask

    // Count posedges from the launch negedge until done. The accepting edge is the first one
    // counted, so the count is ITER+1. If glitch_at is nonzero, drive a stray start with other
    // operands in that cycle.
    task automatic wait_done(input bit w8, input int exp_lat, input int glitch_at, input string tag);
        int          lat      = 0;
        int          busy_cnt = 0;
        bit          seen     = 1'b0;
        logic [63:0] exp;
        logic [63:0] obs;
        while (!seen && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start8  = 1'b0;
            start32 = 1'b0;
            if (lat == glitch_at) begin
                start32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h0000_0009; s32 = 1'b0;
            end
            if (w8 ? done8 : done32) seen = 1'b1;
            else if (w8 ? busy8 : busy32) busy_cnt++;
        end
        obs = w8 ? {48'b0, prod8} : prod32;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        check({tag, " edges to done"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, " busy low at done"}, 64'(w8 ? busy8 : busy32), 64'd0);
        check({tag, " product"}, obs, exp);
    endtask

    // One cycle after done with no new start: the unit is back in IDLE.
    task automatic expect_idle(input bit w8, input string tag);
        @(negedge clk);
        check({tag, " done pulse ended"}, 64'(w8 ? done8 : done32), 64'd0);
        check({tag, " idle not busy"}, 64'(w8 ? busy8 : busy32), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #1;
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset done32", 64'(done32), 64'd0);
        check("reset prod32", prod32, 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset prod8", 64'(prod8), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed small operands: 7 * -3
        launch(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done(0, 18, 0, "s7x-3");
        expect_idle(0, "s7x-3");

        // Stray start in the fifth RUN cycle is ignored
        launch(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done(0, 18, 6, "ignore start");
        expect_idle(0, "ignore start");

        // Unsigned extremes, then the same operands signed, issued back-to-back
        launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        wait_done(0, 18, 0, "u max");
        launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        wait_done(0, 18, 0, "b2b s -1x-1");
        // Signed corners, also back-to-back
        launch(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        wait_done(0, 18, 0, "b2b s min x min");
        launch(0, 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        wait_done(0, 18, 0, "b2b s min x 1");
        expect_idle(0, "s min x 1");

        // Reset asserted in the eighth RUN cycle aborts with no done pulse
        launch(0, 32'd123, 32'd456, 1'b0, ref_mul(0, 32'd123, 32'd456, 1'b0));
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            start32 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", 64'(busy32), 64'd0);
        check("midrun reset done", 64'(done32), 64'd0);
        check("midrun reset product", prod32, 64'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done32) check("no done after abort", 64'(done32), 64'd0);
        end
        launch(0, 32'd3, 32'd4, 1'b0, 64'd12);
        wait_done(0, 18, 0, "post reset 3x4");
        expect_idle(0, "post reset 3x4");

        // WIDTH=8 sweep: random pairs, each run unsigned then signed
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) begin ra = 32'h80; rb = 32'h80; end
            if (i == 1) begin ra = 32'hFF; rb = 32'hFF; end
            for (int s = 0; s < 2; s++) begin
                launch(1, ra, rb, s[0], ref_mul(1, ra, rb, s[0]));
                wait_done(1, 6, 0, "w8 sweep");
            end
        end
        expect_idle(1, "w8 sweep");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
